// File: rtl/cond_unit_pkg.sv
// rtl/cond_unit_pkg.sv - condition codes, flag indices and flag struct shared by the core
package cond_unit_pkg;

    typedef enum logic [3:0] {
        EQ = 4'b0000,
        NE = 4'b0001,
        CS = 4'b0010,
        CC = 4'b0011,
        MI = 4'b0100,
        PL = 4'b0101,
        VS = 4'b0110,
        VC = 4'b0111,
        HI = 4'b1000,
        LS = 4'b1001,
        GE = 4'b1010,
        LT = 4'b1011,
        GT = 4'b1100,
        LE = 4'b1101,
        AL = 4'b1110,
        NV = 4'b1111
    } cond_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

endpackage

// File: rtl/cond_unit_condcheck.sv
// rtl/cond_unit_condcheck.sv - combinational condition-field decode against NZCV
module condcheck
    import cond_unit_pkg::*;
(
    input  logic [3:0] cond_i,
    input  flags_t     flags_i,
    output logic       cond_ex_o
);

    logic ge;

    assign ge = (flags_i.n == flags_i.v);

    always_comb begin
        cond_ex_o = 1'b0;
        case (cond_t'(cond_i))
            EQ: cond_ex_o = flags_i.z;
            NE: cond_ex_o = ~flags_i.z;
            CS: cond_ex_o = flags_i.c;
            CC: cond_ex_o = ~flags_i.c;
            MI: cond_ex_o = flags_i.n;
            PL: cond_ex_o = ~flags_i.n;
            VS: cond_ex_o = flags_i.v;
            VC: cond_ex_o = ~flags_i.v;
            HI: cond_ex_o = flags_i.c & ~flags_i.z;
            LS: cond_ex_o = ~(flags_i.c & ~flags_i.z);
            GE: cond_ex_o = ge;
            LT: cond_ex_o = ~ge;
            GT: cond_ex_o = ~flags_i.z & ge;
            LE: cond_ex_o = ~(~flags_i.z & ge);
            AL: cond_ex_o = 1'b1;
            default: cond_ex_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// rtl/cond_unit.sv - E-stage NZCV flags, condition gating and E/M control register
// Optional squash counter enabled by CONDEX_PERF_EN.
module cond_unit
    import cond_unit_pkg::*;
#(
    parameter int         CNT_W       = 32,
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StallE,
    input  logic             FlushE,
    input  logic [3:0]       CondE,
    input  logic [1:0]       FlagWriteE,
    input  logic [3:0]       ALUFlagsE,
    input  logic             RegWriteE,
    input  logic             MemWriteE,
    input  logic             MemtoRegE,
    input  logic             PCSrcE,
    input  logic             BranchE,
    output logic [3:0]       FlagsE,
    output logic             CondExE,
    output logic             BranchTakenE,
    output logic             RegWriteM,
    output logic             MemWriteM,
    output logic             MemtoRegM,
    output logic             PCSrcM
`ifdef CONDEX_PERF_EN
    ,
    output logic [CNT_W-1:0] SquashCount
`endif
);

    flags_t flags_q, flags_d;
    logic   cond_raw;
    logic   valid;
    logic   reg_write_q, reg_write_d;
    logic   mem_write_q, mem_write_d;
    logic   mem_to_reg_q, mem_to_reg_d;
    logic   pc_src_q, pc_src_d;

    condcheck u_condcheck (
        .cond_i    (CondE),
        .flags_i   (flags_q),
        .cond_ex_o (cond_raw)
    );

    // condcheck treats NV as unconditional; this core retires NV as never-execute.
    assign CondExE      = cond_raw & (cond_t'(CondE) != NV);
    assign valid        = ~StallE & ~FlushE;
    assign BranchTakenE = BranchE & CondExE & ~FlushE;
    assign FlagsE       = flags_q;

    always_comb begin
        flags_d = flags_q;
        if (valid && CondExE) begin
            if (FlagWriteE[1]) begin
                flags_d.n = ALUFlagsE[FLAG_N];
                flags_d.z = ALUFlagsE[FLAG_Z];
            end
            if (FlagWriteE[0]) begin
                flags_d.c = ALUFlagsE[FLAG_C];
                flags_d.v = ALUFlagsE[FLAG_V];
            end
        end
    end

    always_comb begin
        reg_write_d  = reg_write_q;
        mem_write_d  = mem_write_q;
        mem_to_reg_d = mem_to_reg_q;
        pc_src_d     = pc_src_q;
        if (!StallE) begin
            if (FlushE) begin
                reg_write_d  = 1'b0;
                mem_write_d  = 1'b0;
                mem_to_reg_d = 1'b0;
                pc_src_d     = 1'b0;
            end else begin
                reg_write_d  = RegWriteE & CondExE;
                mem_write_d  = MemWriteE & CondExE;
                mem_to_reg_d = MemtoRegE;
                pc_src_d     = PCSrcE & CondExE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q      <= flags_t'(RESET_FLAGS);
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            pc_src_q     <= 1'b0;
        end else begin
            flags_q      <= flags_d;
            reg_write_q  <= reg_write_d;
            mem_write_q  <= mem_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            pc_src_q     <= pc_src_d;
        end
    end

    assign RegWriteM = reg_write_q;
    assign MemWriteM = mem_write_q;
    assign MemtoRegM = mem_to_reg_q;
    assign PCSrcM    = pc_src_q;

`ifdef CONDEX_PERF_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturating: a pegged counter is more useful than one that silently wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (valid && !CondExE && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign SquashCount = cnt_q;
`endif

endmodule

// File: tb/tb_cond_unit.sv
// tb/tb_cond_unit.sv - directed scoreboard bench for cond_unit
module tb_cond_unit;

    localparam int CNT_W = 4;

    localparam logic [3:0] C_EQ = 4'b0000, C_NE = 4'b0001, C_GE = 4'b1010;
    localparam logic [3:0] C_LT = 4'b1011, C_AL = 4'b1110, C_NV = 4'b1111;

    localparam int M_FLAGS = 0, M_CEX = 1, M_BT = 2, M_RW = 3;
    localparam int M_MW = 4, M_MTR = 5, M_PCS = 6, M_CNT = 7;

    typedef struct {
        string       name;
        logic [7:0]  mask;
        logic [3:0]  flags;
        logic        cex;
        logic        bt;
        logic        rw;
        logic        mw;
        logic        mtr;
        logic        pcs;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset, StallE, FlushE;
    logic [3:0] CondE;
    logic [1:0] FlagWriteE;
    logic [3:0] ALUFlagsE;
    logic RegWriteE, MemWriteE, MemtoRegE, PCSrcE, BranchE;
    logic [3:0] FlagsE;
    logic CondExE, BranchTakenE, RegWriteM, MemWriteM, MemtoRegM, PCSrcM;
    logic [CNT_W-1:0] squash_cnt;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    cond_unit #(.CNT_W(CNT_W), .RESET_FLAGS(4'b0000)) dut (
        .clk          (clk),
        .reset        (reset),
        .StallE       (StallE),
        .FlushE       (FlushE),
        .CondE        (CondE),
        .FlagWriteE   (FlagWriteE),
        .ALUFlagsE    (ALUFlagsE),
        .RegWriteE    (RegWriteE),
        .MemWriteE    (MemWriteE),
        .MemtoRegE    (MemtoRegE),
        .PCSrcE       (PCSrcE),
        .BranchE      (BranchE),
        .FlagsE       (FlagsE),
        .CondExE      (CondExE),
        .BranchTakenE (BranchTakenE),
        .RegWriteM    (RegWriteM),
        .MemWriteM    (MemWriteM),
        .MemtoRegM    (MemtoRegM),
        .PCSrcM       (PCSrcM)
`ifdef CONDEX_PERF_EN
        ,
        .SquashCount  (squash_cnt)
`endif
    );

`ifndef CONDEX_PERF_EN
    assign squash_cnt = '0;
`endif

    task automatic cmp(input string name, input string field, input logic [CNT_W-1:0] act,
                       input logic [CNT_W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s: actual %h required %h", name, field, act, req);
        end
    endtask

    // Monitor: outputs are settled mid-cycle, so every pending expectation is checked on negedge.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            if (e.mask[M_FLAGS]) cmp(e.name, "FlagsE", CNT_W'(FlagsE), CNT_W'(e.flags));
            if (e.mask[M_CEX])   cmp(e.name, "CondExE", CNT_W'(CondExE), CNT_W'(e.cex));
            if (e.mask[M_BT])    cmp(e.name, "BranchTakenE", CNT_W'(BranchTakenE), CNT_W'(e.bt));
            if (e.mask[M_RW])    cmp(e.name, "RegWriteM", CNT_W'(RegWriteM), CNT_W'(e.rw));
            if (e.mask[M_MW])    cmp(e.name, "MemWriteM", CNT_W'(MemWriteM), CNT_W'(e.mw));
            if (e.mask[M_MTR])   cmp(e.name, "MemtoRegM", CNT_W'(MemtoRegM), CNT_W'(e.mtr));
            if (e.mask[M_PCS])   cmp(e.name, "PCSrcM", CNT_W'(PCSrcM), CNT_W'(e.pcs));
            if (e.mask[M_CNT])   cmp(e.name, "SquashCount", squash_cnt, e.cnt);
        end
    end

    task automatic drive(input logic [3:0] cond, input logic [1:0] fw, input logic [3:0] alu,
                         input logic rw, input logic mw, input logic mtr, input logic pcs,
                         input logic br, input logic stall, input logic flush, input logic rst);
        CondE = cond; FlagWriteE = fw; ALUFlagsE = alu;
        RegWriteE = rw; MemWriteE = mw; MemtoRegE = mtr; PCSrcE = pcs; BranchE = br;
        StallE = stall; FlushE = flush; reset = rst;
    endtask

    task automatic expect_now(input string name, input logic [7:0] mask, input logic [3:0] flags,
                              input logic cex, input logic bt, input logic rw, input logic mw,
                              input logic mtr, input logic pcs, input logic [CNT_W-1:0] cnt);
        exp_t e;
        e.name = name; e.mask = mask; e.flags = flags; e.cex = cex; e.bt = bt;
        e.rw = rw; e.mw = mw; e.mtr = mtr; e.pcs = pcs; e.cnt = cnt;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [7:0] K_F   = 8'b0000_0001;
    localparam logic [7:0] K_C   = 8'b0000_0010;
    localparam logic [7:0] K_B   = 8'b0000_0100;
    localparam logic [7:0] K_RW  = 8'b0000_1000;
    localparam logic [7:0] K_MW  = 8'b0001_0000;
    localparam logic [7:0] K_MTR = 8'b0010_0000;
    localparam logic [7:0] K_PCS = 8'b0100_0000;
    localparam logic [7:0] K_CNT = 8'b1000_0000;
    localparam logic [7:0] K_M   = K_RW | K_MW | K_MTR | K_PCS;

    initial begin
        logic [7:0] k_rst;
        int         to;
`ifdef CONDEX_PERF_EN
        k_rst = K_F | K_C | K_M | K_CNT;
`else
        k_rst = K_F | K_C | K_M;
`endif
        drive(C_AL, 2'b00, 4'h0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick(); tick();

        drive(C_AL, 2'b11, 4'b0100, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_now("reset_state", k_rst, 4'b0000, 1, 0, 0, 0, 0, 0, '0);
        tick();
        drive(C_EQ, 2'b00, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_now("eq_after_z", K_F | K_C, 4'b0100, 1, 0, 0, 0, 0, 0, '0);
        tick();
        drive(C_NE, 2'b00, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_now("ne_after_z", K_C, 4'b0100, 0, 0, 0, 0, 0, 0, '0);
        tick();

        drive(C_AL, 2'b11, 4'b1001, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_now("al_set_1001", K_C, 4'b0000, 1, 0, 0, 0, 0, 0, '0);
        tick();
        drive(C_GE, 2'b00, 4'h0, 1, 0, 0, 0, 0, 0, 0, 0);
        expect_now("ge_pass", K_F | K_C, 4'b1001, 1, 0, 0, 0, 0, 0, '0);
        tick();
        drive(C_LT, 2'b00, 4'h0, 1, 0, 1, 0, 0, 0, 0, 0);
        expect_now("lt_fail", K_C | K_RW, 4'b1001, 0, 0, 1, 0, 0, 0, '0);
        tick();
        drive(C_AL, 2'b11, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_now("lt_gated", K_RW | K_MTR, 4'b0000, 0, 0, 0, 0, 1, 0, '0);
        tick();

        drive(C_AL, 2'b10, 4'b1111, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_now("flags_cleared", K_F | K_MTR, 4'b0000, 0, 0, 0, 0, 0, 0, '0);
        tick();
        drive(C_NE, 2'b11, 4'b0011, 0, 1, 0, 1, 1, 0, 0, 0);
        expect_now("nz_only_write", K_F | K_C | K_B, 4'b1100, 0, 0, 0, 0, 0, 0, '0);
        tick();
        drive(C_EQ, 2'b00, 4'h0, 0, 1, 0, 1, 1, 0, 0, 0);
        expect_now("ne_squashed", K_F | K_C | K_B | K_MW | K_PCS, 4'b1100, 1, 1, 0, 0, 0, 0, '0);
        tick();
        drive(C_AL, 2'b00, 4'h0, 1, 0, 0, 0, 1, 0, 1, 0);
        expect_now("eq_taken", K_B | K_MW | K_PCS, 4'b1100, 0, 0, 0, 1, 0, 1, '0);
        tick();
        drive(C_AL, 2'b00, 4'h0, 1, 0, 0, 0, 0, 0, 0, 0);
        expect_now("flush_zeros", K_M, 4'b1100, 0, 0, 0, 0, 0, 0, '0);
        tick();

        drive(C_AL, 2'b11, 4'b0011, 0, 0, 0, 0, 0, 1, 1, 0);
        expect_now("stall_flush_0", K_F | K_RW, 4'b1100, 0, 0, 1, 0, 0, 0, '0);
        tick();
        expect_now("stall_flush_1", K_F | K_RW, 4'b1100, 0, 0, 1, 0, 0, 0, '0);
        tick();
        drive(C_AL, 2'b11, 4'b0011, 0, 0, 0, 0, 0, 0, 1, 0);
        expect_now("stall_held", K_F | K_RW, 4'b1100, 0, 0, 1, 0, 0, 0, '0);
        tick();
        drive(C_NV, 2'b11, 4'b0011, 1, 0, 0, 0, 1, 0, 0, 0);
        expect_now("flush_only", K_F | K_RW | K_C | K_B, 4'b1100, 0, 0, 0, 0, 0, 0, '0);
        tick();
        drive(C_NV, 2'b00, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_now("nv_no_effect", K_F | K_RW | K_C, 4'b1100, 0, 0, 0, 0, 0, 0, '0);
        tick();

        drive(C_AL, 2'b11, 4'b0011, 1, 0, 0, 0, 0, 0, 0, 1);
        expect_now("pre_reset", K_F | K_C, 4'b1100, 1, 0, 0, 0, 0, 0, '0);
        tick();
        drive(C_AL, 2'b00, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_now("mid_reset", k_rst, 4'b0000, 1, 0, 0, 0, 0, 0, '0);
        tick();

`ifdef CONDEX_PERF_EN
        for (int i = 0; i < 3; i++) begin
            drive(C_NV, 2'b00, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0);
            expect_now("cnt_step", K_CNT | K_C, 4'h0, 0, 0, 0, 0, 0, 0, CNT_W'(i));
            tick();
        end
        drive(C_NV, 2'b00, 4'h0, 0, 0, 0, 0, 0, 1, 0, 0);
        expect_now("cnt_stall", K_CNT, 4'h0, 0, 0, 0, 0, 0, 0, CNT_W'(3));
        tick();
        drive(C_NV, 2'b00, 4'h0, 0, 0, 0, 0, 0, 0, 1, 0);
        expect_now("cnt_flush", K_CNT, 4'h0, 0, 0, 0, 0, 0, 0, CNT_W'(3));
        tick();
        for (int i = 0; i < 20; i++) begin
            drive(C_NV, 2'b00, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0);
            expect_now("cnt_run", K_CNT | K_C, 4'h0, 0, 0, 0, 0, 0, 0,
                       (3 + i > 15) ? CNT_W'(15) : CNT_W'(3 + i));
            tick();
        end
        drive(C_NV, 2'b00, 4'h0, 0, 0, 0, 0, 0, 0, 0, 1);
        expect_now("cnt_sat", K_CNT, 4'h0, 0, 0, 0, 0, 0, 0, 4'hF);
        tick();
        drive(C_AL, 2'b00, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_now("cnt_reset", K_CNT, 4'h0, 0, 0, 0, 0, 0, 0, '0);
        tick();
`endif

        to = 0;
        while (sb.size() > 0 && to < 10) begin
            tick();
            to++;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: actual %0d pending required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cond_unit.md
# cond_unit

Execute-stage conditional-execution unit of the pipelined core. It holds the architectural NZCV flag register and evaluates each instruction's 4-bit condition field against those flags. It gates the instruction's side effects (register write, memory write, PC redirect, flag update) by the result, then registers the gated controls into the Memory stage. It sits between the decoder's E-stage control register (upstream) and the M-stage datapath and fetch redirect (downstream).

## Interface
- CNT_W, 32, width of squash counter (used only with CONDEX_PERF_EN)
- RESET_FLAGS, 4'b0000, flag register value after reset, ordered {N,Z,C,V}

Ports:
- clk  in  1  core clock, all state on rising edge
- reset  in  1  synchronous, active-high
- StallE  in  1  E/M register and flags hold
- FlushE  in  1  instruction in E is a bubble
- CondE  in  4  instruction condition field
- FlagWriteE  in  2  [1]=update N,Z; [0]=update C,V
- ALUFlagsE  in  4  ALU result flags {N,Z,C,V}
- RegWriteE, MemWriteE, MemtoRegE, PCSrcE, BranchE  in  1 each  ungated controls
- FlagsE  out  4  current flag register
- CondExE  out  1  condition passed (combinational)
- BranchTakenE  out  1  BranchE & CondExE & ~FlushE, combinational, to fetch
- RegWriteM, MemWriteM, MemtoRegM, PCSrcM  out  1 each  registered gated controls
- SquashCount  out  CNT_W  failed-condition count (only with CONDEX_PERF_EN)

## Operation
- Condition decode over {N,Z,C,V}: EQ Z; NE ~Z; CS C; CC ~C; MI N; PL ~N; VS V; VC ~V; HI C&~Z; LS ~(C&~Z); GE N==V; LT N!=V; GT ~Z&(N==V); LE ~(~Z&(N==V)); 1110 always.
- CondE = 4'b1111 is never-execute: CondExE = 0, never X.
- valid = ~StallE & ~FlushE.
- Flag update at edge: N,Z <= ALUFlagsE[3:2] when FlagWriteE[1] & CondExE & valid; C,V <= ALUFlagsE[1:0] when FlagWriteE[0] & CondExE & valid; otherwise hold.
- E/M register, priority order:
  - reset: all M outputs 0.
  - StallE: hold, and FlushE is ignored.
  - FlushE: load all zeros.
  - Otherwise: RegWriteM <= RegWriteE&CondExE; MemWriteM <= MemWriteE&CondExE; PCSrcM <= PCSrcE&CondExE; MemtoRegM <= MemtoRegE.
- Reset values: FlagsE = RESET_FLAGS; all M outputs 0; SquashCount 0.

## Timing
- CondExE and BranchTakenE: zero latency, combinational from CondE and the flag register.
- Flags written at edge N are visible on FlagsE and CondExE in cycle N+1. No same-cycle bypass is required.
- Gated controls reach M outputs 1 cycle after a valid E cycle.
- Reset asserted mid-stream: the flag write for that edge is discarded and the register takes RESET_FLAGS.
- StallE and FlushE high together: stall wins; nothing changes.

## Configuration
- CONDEX_PERF_EN defined:
  - SquashCount increments by 1 per valid cycle with CondExE = 0.
  - It saturates at all-ones and never wraps.
  - It does not increment during stall, flush or reset.
- CONDEX_PERF_EN undefined: the SquashCount port and counter are absent, and all other behaviour is identical.

## Structure
- Shared core package holds:
  - cond_t enum: EQ..AL plus NV = 4'b1111.
  - Flag bit index constants: N=3, Z=2, C=1, V=0.
  - flags_t packed struct.
- Sub-module: the existing combinational condcheck, instantiated for decode. cond_unit wraps its output to force 0 for NV.
- Flag register, E/M register and counter live in cond_unit.

## Test plan
- Reset, then CondE=AL, FlagWriteE=2'b11, ALUFlagsE=4'b0100 -> FlagsE=4'b0100 next cycle. Then CondE=EQ gives CondExE=1, and CondE=NE gives 0.
- FlagsE=4'b1001, CondE=GE, RegWriteE=1 -> CondExE=1, RegWriteM=1 next cycle. CondE=LT -> RegWriteM=0.
- FlagsE=0000, FlagWriteE=2'b10, ALUFlagsE=4'b1111, CondE=AL -> FlagsE=4'b1100 (C,V held).
- CondE=NE with Z=1, FlagWriteE=2'b11, MemWriteE=1, PCSrcE=1, BranchE=1 -> flags unchanged; MemWriteM=0, PCSrcM=0, BranchTakenE=0.
- Prior RegWriteM=1; StallE=1 and FlushE=1 for 2 cycles -> RegWriteM stays 1 and FlagsE unchanged. Then FlushE only -> RegWriteM=0.
- CONDEX_PERF_EN, CNT_W=4: 20 valid CondE=NV cycles -> SquashCount saturates at 4'hF. CondE=4'b1111 never yields X. Reset -> 0.
